// File: rtl/reg_writeback_queue.sv
// Writeback queue between execute and the register file write port: in-order FIFO,
// one registered write per cycle, plus read-after-write pending flags for decode.
module reg_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [ADDR_W-1:0]          res_addr,
    input  logic [DATA_W-1:0]          res_data,
    input  logic                       wr_hold,
    input  logic                       flush,
    output logic                       reg_wr,
    output logic [ADDR_W-1:0]          reg_waddr,
    output logic [DATA_W-1:0]          reg_din,
    input  logic [ADDR_W-1:0]          chk_addr1,
    input  logic [ADDR_W-1:0]          chk_addr2,
    output logic                       chk_pend1,
    output logic                       chk_pend2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              reg_wr_r;
    logic [ADDR_W-1:0] reg_waddr_r;
    logic [DATA_W-1:0] reg_din_r;

    logic              res_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DEPTH-1:0]  entry_valid_s;
    logic [PTR_W-1:0]  offset_s;
    logic              pend1_s;
    logic              pend2_s;

    assign res_ready_s = (count_r < CNT_W'(DEPTH)) && !rst;
    assign push_s      = res_valid && res_ready_s && !flush;
    assign pop_s       = (count_r != {CNT_W{1'b0}}) && !wr_hold && !flush;

    // Pointer, occupancy and registered write-port state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            reg_wr_r    <= 1'b0;
            reg_waddr_r <= {ADDR_W{1'b0}};
            reg_din_r   <= {DATA_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            reg_wr_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
                reg_wr_r    <= 1'b1;
                reg_waddr_r <= addr_mem_r[rd_ptr_r];
                reg_din_r   <= data_mem_r[rd_ptr_r];
            end else begin
                reg_wr_r <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale slots are masked by occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= res_addr;
            data_mem_r[wr_ptr_r] <= res_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid_s = {DEPTH{1'b0}};
        offset_s      = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offset_s         = PTR_W'(i) - rd_ptr_r;
            entry_valid_s[i] = ({1'b0, offset_s} < count_r);
        end
    end

    // Pending flags cover both queued entries and the write currently on the port.
    always_comb begin
        pend1_s = reg_wr_r && (reg_waddr_r == chk_addr1);
        pend2_s = reg_wr_r && (reg_waddr_r == chk_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            pend1_s = pend1_s | (entry_valid_s[i] && (addr_mem_r[i] == chk_addr1));
            pend2_s = pend2_s | (entry_valid_s[i] && (addr_mem_r[i] == chk_addr2));
        end
    end

    assign res_ready = res_ready_s;
    assign reg_wr    = reg_wr_r;
    assign reg_waddr = reg_waddr_r;
    assign reg_din   = reg_din_r;
    assign chk_pend1 = pend1_s;
    assign chk_pend2 = pend2_s;
    assign count     = count_r;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a write-port scoreboard.
module tb_reg_writeback_queue;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;
    logic              wr_hold;
    logic              flush;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_din;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_pend1;
    logic              chk_pend2;
    logic [2:0]        count;

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W-1:0] sb [$];

    reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_data(res_data), .wr_hold(wr_hold), .flush(flush),
        .reg_wr(reg_wr), .reg_waddr(reg_waddr), .reg_din(reg_din),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_pend1(chk_pend1), .chk_pend2(chk_pend2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        res_valid = 1'b1;
        res_addr  = a;
        res_data  = d;
    endtask

    // Every write pulse must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {27'd0, reg_waddr}, 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = sb.pop_front();
                check("sb_waddr", {27'd0, reg_waddr}, {27'd0, e[ADDR_W+DATA_W-1:DATA_W]});
                check("sb_din", {16'd0, reg_din}, {16'd0, e[DATA_W-1:0]});
            end
        end
    end

    initial begin
        rst = 1'b1; res_valid = 1'b1; res_addr = 5'd31; res_data = 16'hBEEF;
        wr_hold = 1'b0; flush = 1'b0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;

        // Reset held for two edges with a result offered
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ready", {31'd0, res_ready}, 32'd0);
            check("rst_wr", {31'd0, reg_wr}, 32'd0);
            check("rst_count", {29'd0, count}, 32'd0);
        end
        rst = 1'b0; res_valid = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, res_ready}, 32'd1);

        // Single result
        drive(5'd3, 16'h0F0F);
        sb.push_back({5'd3, 16'h0F0F});
        step();
        res_valid = 1'b0;
        check("single_count1", {29'd0, count}, 32'd1);
        check("single_nowr", {31'd0, reg_wr}, 32'd0);
        step();
        check("single_wr", {31'd0, reg_wr}, 32'd1);
        check("single_waddr", {27'd0, reg_waddr}, 32'd3);
        check("single_din", {16'd0, reg_din}, 32'h0F0F);
        check("single_count0", {29'd0, count}, 32'd0);
        step();
        check("single_pulse_end", {31'd0, reg_wr}, 32'd0);

        // Fill with the write port held
        wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 16'(i * 16'h1111));
            check("fill_ready", {31'd0, res_ready}, 32'd1);
            sb.push_back({5'(i), 16'(i * 16'h1111)});
            step();
        end
        drive(5'd8, 16'h8888);
        #1;
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, res_ready}, 32'd0);
        step();
        check("full_hold_count", {29'd0, count}, 32'd4);
        check("full_hold_wr", {31'd0, reg_wr}, 32'd0);

        // Release the hold; the fifth result gets in once a slot opens
        wr_hold = 1'b0;
        step();
        check("drain1_waddr", {27'd0, reg_waddr}, 32'd1);
        check("drain1_count", {29'd0, count}, 32'd3);
        check("drain1_ready", {31'd0, res_ready}, 32'd1);
        sb.push_back({5'd8, 16'h8888});
        step();
        res_valid = 1'b0;
        check("drain2_waddr", {27'd0, reg_waddr}, 32'd2);
        check("drain2_count", {29'd0, count}, 32'd3);

        // Hazard flags while 3, 4, 8 are still queued
        chk_addr1 = 5'd8; chk_addr2 = 5'd3;
        #1;
        check("haz_p1_q", {31'd0, chk_pend1}, 32'd1);
        check("haz_p2_q", {31'd0, chk_pend2}, 32'd1);
        step();
        check("drain3_waddr", {27'd0, reg_waddr}, 32'd3);
        check("haz_p2_flight", {31'd0, chk_pend2}, 32'd1);
        step();
        check("drain4_waddr", {27'd0, reg_waddr}, 32'd4);
        check("haz_p1_q8", {31'd0, chk_pend1}, 32'd1);
        check("haz_p2_clear", {31'd0, chk_pend2}, 32'd0);
        step();
        check("drain5_wr", {31'd0, reg_wr}, 32'd1);
        check("drain5_waddr", {27'd0, reg_waddr}, 32'd8);
        check("haz_p1_flight", {31'd0, chk_pend1}, 32'd1);
        check("drain5_count", {29'd0, count}, 32'd0);
        step();
        check("drain_idle_wr", {31'd0, reg_wr}, 32'd0);
        check("haz_p1_clear", {31'd0, chk_pend1}, 32'd0);

        // Flush with a push in the same cycle
        wr_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'(10 + i), 16'(16'hA000 + i));
            sb.push_back({5'(10 + i), 16'(16'hA000 + i)});
            step();
        end
        check("pre_flush_count", {29'd0, count}, 32'd3);
        drive(5'd20, 16'hDEAD);
        flush = 1'b1;
        step();
        flush = 1'b0; res_valid = 1'b0; wr_hold = 1'b0;
        sb.delete();
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_ready", {31'd0, res_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_nowr", {31'd0, reg_wr}, 32'd0);
            check("flush_waddr", {27'd0, reg_waddr}, 32'd8);
        end

        // Steady stream across pointer wrap
        wr_hold = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic [DATA_W-1:0] d;
            d = 16'($urandom);
            if (k == 2) wr_hold = 1'b0;
            drive(5'((k * 7 + 1) % 32), d);
            #1;
            check("stream_ready", {31'd0, res_ready}, 32'd1);
            sb.push_back({5'((k * 7 + 1) % 32), d});
            step();
            if (k >= 2) begin
                check("stream_count", {29'd0, count}, 32'd2);
                check("stream_wr", {31'd0, reg_wr}, 32'd1);
            end
        end
        res_valid = 1'b0;
        for (int n = 0; n < 20 && sb.size() > 0; n++) step();
        step();
        check("stream_drained", sb.size(), 32'd0);
        check("stream_count_end", {29'd0, count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
